// File: rtl/spi_status_tx_if.sv
// Bundle of SPI pins and core-side frame handshake for spi_status_tx.
// The slave modport is the FPGA-side transmitter; the master modport is the MCU/core side.
interface spi_status_tx_if #(
   parameter int FRAME_BITS = 64
);
   logic                  sck;
   logic                  cs;
   logic                  sdo;
   logic [FRAME_BITS-1:0] frame_data;
   logic                  frame_valid;
   logic                  busy;
   logic                  done;
   logic                  aborted;
   logic                  stale;

   modport slave (
      input  sck, cs, frame_data, frame_valid,
      output sdo, busy, done, aborted, stale
   );

   modport master (
      output sck, cs, frame_data, frame_valid,
      input  sdo, busy, done, aborted, stale
   );
endinterface

// File: rtl/spi_status_tx.sv
// SPI mode-0 slave transmitter returning a staged status frame on sdo, MSB first.
// Define SPI_STATUS_TX_CRC_EN to append a CRC-8 (poly 0x07) byte after the payload.
module spi_status_tx #(
   parameter int FRAME_BITS  = 64,
   parameter int SYNC_STAGES = 2
) (
   input logic            clk,
   input logic            reset,
   spi_status_tx_if.slave bus
);
`ifdef SPI_STATUS_TX_CRC_EN
   localparam int TOTAL_BITS = FRAME_BITS + 8;
`else
   localparam int TOTAL_BITS = FRAME_BITS;
`endif
   localparam int              CNT_W   = $clog2(TOTAL_BITS + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TOTAL_BITS);

   typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;

   logic [SYNC_STAGES-1:0] sck_sync_p0, cs_sync_p0;
   logic                   sck_s, cs_s;
   logic                   sck_p1, cs_p1;
   logic                   sck_rise_p2, sck_fall_p2, cs_rise_p2, cs_fall_p2;

   state_t                  state;
   logic [FRAME_BITS-1:0]   staging;
   logic [TOTAL_BITS-1:0]   shreg;
   logic [TOTAL_BITS-1:0]   load_val;
   logic [CNT_W-1:0]        cnt;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + 1'b1;
   endfunction

`ifdef SPI_STATUS_TX_CRC_EN
   function automatic logic [7:0] crc8(input logic [FRAME_BITS-1:0] d);
      logic [7:0] c;
      logic       fb;
      c = 8'h00;
      for (int i = FRAME_BITS - 1; i >= 0; i--) begin
         fb = c[7] ^ d[i];
         c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
      end
      return c;
   endfunction

   function automatic logic [TOTAL_BITS-1:0] load_word(input logic [FRAME_BITS-1:0] d);
      return {d, crc8(d)};
   endfunction
`else
   function automatic logic [TOTAL_BITS-1:0] load_word(input logic [FRAME_BITS-1:0] d);
      return d;
   endfunction
`endif

   assign sck_s    = sck_sync_p0[SYNC_STAGES-1];
   assign cs_s     = cs_sync_p0[SYNC_STAGES-1];
   // Same-cycle frame_valid wins over the staged copy so fresh data goes out.
   assign load_val = load_word(bus.frame_valid ? bus.frame_data : staging);

   // p0: synchronizers, p1: delayed copies, p2: registered single-cycle edge pulses
   always_ff @(posedge clk) begin
      if (reset) begin
         sck_sync_p0 <= '0;
         cs_sync_p0  <= '1;
         sck_p1      <= 1'b0;
         cs_p1       <= 1'b1;
         sck_rise_p2 <= 1'b0;
         sck_fall_p2 <= 1'b0;
         cs_rise_p2  <= 1'b0;
         cs_fall_p2  <= 1'b0;
      end else begin
         sck_sync_p0 <= {sck_sync_p0[SYNC_STAGES-2:0], bus.sck};
         cs_sync_p0  <= {cs_sync_p0[SYNC_STAGES-2:0], bus.cs};
         sck_p1      <= sck_s;
         cs_p1       <= cs_s;
         sck_rise_p2 <= sck_s & ~sck_p1;
         sck_fall_p2 <= ~sck_s & sck_p1;
         cs_rise_p2  <= cs_s & ~cs_p1;
         cs_fall_p2  <= ~cs_s & cs_p1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         bus.sdo     <= 1'b0;
         bus.busy    <= 1'b0;
         bus.done    <= 1'b0;
         bus.aborted <= 1'b0;
         bus.stale   <= 1'b0;
         staging     <= '0;
         shreg       <= '0;
         cnt         <= '0;
      end else begin
         bus.done    <= 1'b0;
         bus.aborted <= 1'b0;
         if (bus.frame_valid) begin
            staging   <= bus.frame_data;
            bus.stale <= 1'b0;
         end
         case (state)
            IDLE: begin
               bus.sdo <= 1'b0;
               if (cs_fall_p2) begin
                  // shreg holds the bits still to come; sdo already carries the MSB
                  shreg     <= load_val << 1;
                  bus.sdo   <= load_val[TOTAL_BITS-1];
                  cnt       <= '0;
                  bus.busy  <= 1'b1;
                  bus.stale <= 1'b1;
                  state     <= SHIFT;
               end
            end
            SHIFT: begin
               if (sck_rise_p2)
                  cnt <= sat_inc(cnt);
               if (sck_fall_p2) begin
                  if (cnt < CNT_MAX) begin
                     bus.sdo <= shreg[TOTAL_BITS-1];
                     shreg   <= shreg << 1;
                  end else begin
                     bus.sdo <= 1'b0;
                  end
               end
               if (cs_rise_p2)
                  state <= FINISH;
            end
            FINISH: begin
               bus.done    <= (cnt == CNT_MAX);
               bus.aborted <= (cnt != CNT_MAX);
               bus.busy    <= 1'b0;
               bus.sdo     <= 1'b0;
               state       <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
